// File: rtl/vector_reg_sequencer_if.sv
// Bus bundle between vector_reg_sequencer, the issue/writeback logic and one
// vector register: command, element stream, two writeback ports, register port.
interface vector_reg_sequencer_if #(
  parameter int VECTOR_REG_DEPTH = 64,
  parameter int VECTOR_REG_WIDTH = 64
);
  localparam int AW = $clog2(VECTOR_REG_DEPTH);

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [AW:0]                 cmd_vl;
  logic [AW-1:0]               rd_addr;
  logic [VECTOR_REG_WIDTH-1:0] rd_data;
  logic                        elem_valid;
  logic                        elem_ready;
  logic [VECTOR_REG_WIDTH-1:0] elem_data;
  logic [AW-1:0]               elem_idx;
  logic                        elem_last;
  logic                        busy;
  logic                        wb_a_valid;
  logic                        wb_a_ready;
  logic [AW-1:0]               wb_a_addr;
  logic [VECTOR_REG_WIDTH-1:0] wb_a_data;
  logic                        wb_b_valid;
  logic                        wb_b_ready;
  logic [AW-1:0]               wb_b_addr;
  logic [VECTOR_REG_WIDTH-1:0] wb_b_data;
  logic                        write;
  logic [AW-1:0]               write_addr;
  logic [VECTOR_REG_WIDTH-1:0] write_data;

  modport master (
    output cmd_valid, cmd_vl, rd_data, elem_ready,
           wb_a_valid, wb_a_addr, wb_a_data, wb_b_valid, wb_b_addr, wb_b_data,
    input  cmd_ready, rd_addr, elem_valid, elem_data, elem_idx, elem_last, busy,
           wb_a_ready, wb_b_ready, write, write_addr, write_data
  );

  modport slave (
    input  cmd_valid, cmd_vl, rd_data, elem_ready,
           wb_a_valid, wb_a_addr, wb_a_data, wb_b_valid, wb_b_addr, wb_b_data,
    output cmd_ready, rd_addr, elem_valid, elem_data, elem_idx, elem_last, busy,
           wb_a_ready, wb_b_ready, write, write_addr, write_data
  );
endinterface

// File: rtl/vector_reg_sequencer.sv
// Streams VL elements of one vector register and arbitrates its write port
// between ALU (A) and load (B) writeback. Define VREG_SEQ_FIXED_PRIO_EN for A-over-B priority.
module vector_reg_sequencer #(
  parameter int VECTOR_REG_DEPTH = 64,
  parameter int VECTOR_REG_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  vector_reg_sequencer_if.slave bus
);
  localparam int AW = $clog2(VECTOR_REG_DEPTH);
  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(VECTOR_REG_DEPTH);
  localparam logic [AW:0] ONE       = (AW+1)'(1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                      state, next_state;
  logic [AW-1:0]               idx;
  logic [AW:0]                 len;
  logic [AW:0]                 len_in;
  logic                        accept;
  logic                        streaming;
  logic                        last;
  logic                        grant_a, grant_b;
  logic                        write_q;
  logic [AW-1:0]               write_addr_q;
  logic [VECTOR_REG_WIDTH-1:0] write_data_q;

  assign len_in    = (bus.cmd_vl > DEPTH_LEN) ? DEPTH_LEN : bus.cmd_vl;
  assign streaming = (state == STREAM);
  assign accept    = (state == IDLE) && bus.cmd_valid;
  assign last      = streaming && ({1'b0, idx} == len - ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (accept && len_in != '0) next_state = STREAM;
      STREAM: if (bus.elem_ready && last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // idx is left untouched in IDLE so rd_addr keeps pointing at the last element read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      len <= '0;
    end else if (accept) begin
      len <= len_in;
      if (len_in != '0) idx <= '0;
    end else if (streaming && bus.elem_ready && !last) begin
      idx <= idx + 1'b1;
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.busy       = streaming;
  assign bus.elem_valid = streaming;
  assign bus.elem_last  = last;
  assign bus.elem_idx   = idx;
  assign bus.rd_addr    = idx;
  assign bus.elem_data  = bus.rd_data;

`ifdef VREG_SEQ_FIXED_PRIO_EN
  assign grant_a = !reset && bus.wb_a_valid;
  assign grant_b = !reset && bus.wb_b_valid && !bus.wb_a_valid;
`else
  logic ptr_b;

  assign grant_a = !reset && bus.wb_a_valid && (!bus.wb_b_valid || !ptr_b);
  assign grant_b = !reset && bus.wb_b_valid && (!bus.wb_a_valid || ptr_b);

  // Pointer always moves to the side that lost (or did not request) this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ptr_b <= 1'b0;
    else if (grant_a) ptr_b <= 1'b1;
    else if (grant_b) ptr_b <= 1'b0;
  end
`endif

  assign bus.wb_a_ready = grant_a;
  assign bus.wb_b_ready = grant_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q      <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      write_q <= grant_a || grant_b;
      if (grant_a) begin
        write_addr_q <= bus.wb_a_addr;
        write_data_q <= bus.wb_a_data;
      end else if (grant_b) begin
        write_addr_q <= bus.wb_b_addr;
        write_data_q <= bus.wb_b_data;
      end
    end
  end

  assign bus.write      = write_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_vector_reg_sequencer.sv
// Directed bench for vector_reg_sequencer with a behavioural 64x64 vector
// register attached to its read/write ports.
module tb_vector_reg_sequencer;
  localparam int DEPTH = 64;
  localparam int WIDTH = 64;
  localparam int AW    = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] mem [DEPTH];
  int               checks = 0;
  int               errors = 0;

  vector_reg_sequencer_if #(.VECTOR_REG_DEPTH(DEPTH), .VECTOR_REG_WIDTH(WIDTH)) bus();

  vector_reg_sequencer #(.VECTOR_REG_DEPTH(DEPTH), .VECTOR_REG_WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.rd_data = mem[bus.rd_addr];
  always @(posedge clk) if (bus.write) mem[bus.write_addr] <= bus.write_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wb_a_valid = 1'b1;
    bus.wb_b_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.elem_valid, bus.elem_last, bus.busy, bus.write, bus.wb_a_ready, bus.wb_b_ready} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 1000000", {bus.cmd_ready, bus.elem_valid, bus.elem_last, bus.busy, bus.write, bus.wb_a_ready, bus.wb_b_ready});
    end
    checks++;
    if (bus.elem_idx !== 6'd0 || bus.rd_addr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_idx: got elem_idx %0d rd_addr %0d expected 0 0", bus.elem_idx, bus.rd_addr);
    end
    checks++;
    if (bus.write_addr !== 6'd0 || bus.write_data !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_write: got addr %0d data %h expected 0 0", bus.write_addr, bus.write_data);
    end
    bus.wb_a_valid = 1'b0;
    bus.wb_b_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic          exp_a;
    logic [AW-1:0] prev_addr = '0;
    logic [63:0]   prev_data = '0;
    for (int k = 0; k < 6; k++) begin
      bus.wb_a_valid = (k < 4);
      bus.wb_b_valid = (k < 5);
      bus.wb_a_addr  = 6'(10 + k);
      bus.wb_a_data  = 64'hA0 + 64'(k);
      bus.wb_b_addr  = 6'(20 + k);
      bus.wb_b_data  = 64'hB0 + 64'(k);
`ifdef VREG_SEQ_FIXED_PRIO_EN
      exp_a = (k < 4);
`else
      exp_a = (k < 4) && (k % 2 == 0);
`endif
      @(negedge clk);
      checks++;
      if ({bus.wb_a_ready, bus.wb_b_ready} !== {exp_a, (k < 5) && !exp_a}) begin
        errors++;
        $display("[TB] FAIL arb_grant k=%0d: got a=%b b=%b expected a=%b b=%b", k, bus.wb_a_ready, bus.wb_b_ready, exp_a, (k < 5) && !exp_a);
      end
      if (k > 0) begin
        checks++;
        if (bus.write !== 1'b1 || bus.write_addr !== prev_addr || bus.write_data !== prev_data) begin
          errors++;
          $display("[TB] FAIL arb_write k=%0d: got %b/%0d/%h expected 1/%0d/%h", k, bus.write, bus.write_addr, bus.write_data, prev_addr, prev_data);
        end
      end
      prev_addr = exp_a ? bus.wb_a_addr : bus.wb_b_addr;
      prev_data = exp_a ? bus.wb_a_data : bus.wb_b_data;
      tick();
    end
    bus.wb_a_valid = 1'b0;
    bus.wb_b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arb_idle_write: got %b expected 0", bus.write);
    end
    tick();
  endtask

  task automatic preload_register();
    for (int i = 0; i < DEPTH; i++) begin
      bus.wb_a_valid = 1'b1;
      bus.wb_a_addr  = 6'(i);
      bus.wb_a_data  = 64'h100 + 64'(i);
      @(negedge clk);
      checks++;
      if (bus.wb_a_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL preload_grant i=%0d: got %b expected 1", i, bus.wb_a_ready);
      end
      if (i > 0) begin
        checks++;
        if (bus.write !== 1'b1 || bus.write_addr !== 6'(i - 1)) begin
          errors++;
          $display("[TB] FAIL preload_write i=%0d: got %b/%0d expected 1/%0d", i, bus.write, bus.write_addr, i - 1);
        end
      end
      tick();
    end
    bus.wb_a_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stream4();
    bus.elem_ready = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_vl     = 7'd4;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL s4_accept: got cmd_ready %b expected 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.elem_valid, bus.busy, bus.cmd_ready, bus.elem_last} !== {3'b110, i == 3}) begin
        errors++;
        $display("[TB] FAIL s4_flags i=%0d: got %b expected %b", i, {bus.elem_valid, bus.busy, bus.cmd_ready, bus.elem_last}, {3'b110, i == 3});
      end
      checks++;
      if (bus.elem_idx !== 6'(i) || bus.elem_data !== 64'h100 + 64'(i)) begin
        errors++;
        $display("[TB] FAIL s4_elem i=%0d: got %0d/%h expected %0d/%h", i, bus.elem_idx, bus.elem_data, i, 64'h100 + 64'(i));
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({bus.elem_valid, bus.busy, bus.cmd_ready} !== 3'b001 || bus.rd_addr !== 6'd3) begin
      errors++;
      $display("[TB] FAIL s4_done: got %b rd_addr %0d expected 001 rd_addr 3", {bus.elem_valid, bus.busy, bus.cmd_ready}, bus.rd_addr);
    end
  endtask

  task automatic test_stall();
    logic [4:0] rdy = 5'b10101;
    int         exp_idx = 0;
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_vl    = 7'd3;
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.elem_ready = rdy[c];
      @(negedge clk);
      checks++;
      if (bus.elem_valid !== 1'b1 || bus.elem_idx !== 6'(exp_idx) || bus.elem_data !== 64'h100 + 64'(exp_idx) || bus.elem_last !== (exp_idx == 2)) begin
        errors++;
        $display("[TB] FAIL stall_elem c=%0d: got v%b idx %0d data %h last %b expected v1 idx %0d data %h last %b", c, bus.elem_valid, bus.elem_idx, bus.elem_data, bus.elem_last, exp_idx, 64'h100 + 64'(exp_idx), exp_idx == 2);
      end
      if (rdy[c]) exp_idx++;
      tick();
    end
    bus.elem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.elem_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_done: got valid %b cmd_ready %b expected 0 1", bus.elem_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_zero_len();
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_vl    = 7'd0;
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.elem_valid, bus.busy, bus.cmd_ready} !== 3'b001 || bus.rd_addr !== 6'd2) begin
        errors++;
        $display("[TB] FAIL zero_len c=%0d: got %b rd_addr %0d expected 001 rd_addr 2", c, {bus.elem_valid, bus.busy, bus.cmd_ready}, bus.rd_addr);
      end
      tick();
    end
  endtask

  task automatic test_clamp();
    int cnt = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_vl    = 7'd100;
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.elem_valid === 1'b1) begin
        checks++;
        if (bus.elem_idx !== 6'(cnt) || bus.elem_data !== 64'h100 + 64'(cnt) || bus.elem_last !== (cnt == 63)) begin
          errors++;
          $display("[TB] FAIL clamp_elem n=%0d: got idx %0d data %h last %b expected idx %0d data %h last %b", cnt, bus.elem_idx, bus.elem_data, bus.elem_last, cnt % 64, 64'h100 + 64'(cnt), cnt == 63);
        end
        cnt++;
      end
      tick();
    end
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("[TB] FAIL clamp_count: got %0d elements expected 64", cnt);
    end
  endtask

  task automatic test_write_during_stream();
    logic [63:0] exp_data;
    bus.cmd_valid = 1'b1;
    bus.cmd_vl    = 7'd8;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.wb_a_valid = (i == 2);
      bus.wb_a_addr  = 6'd5;
      bus.wb_a_data  = 64'hDEAD;
      exp_data = (i == 5) ? 64'hDEAD : 64'h100 + 64'(i);
      @(negedge clk);
      checks++;
      if (bus.elem_idx !== 6'(i) || bus.elem_data !== exp_data) begin
        errors++;
        $display("[TB] FAIL wds_elem i=%0d: got %0d/%h expected %0d/%h", i, bus.elem_idx, bus.elem_data, i, exp_data);
      end
      if (i == 2) begin
        checks++;
        if (bus.wb_a_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL wds_grant: got %b expected 1", bus.wb_a_ready);
        end
      end
      if (i == 3) begin
        checks++;
        if (bus.write !== 1'b1 || bus.write_addr !== 6'd5 || bus.write_data !== 64'hDEAD) begin
          errors++;
          $display("[TB] FAIL wds_write: got %b/%0d/%h expected 1/5/dead", bus.write, bus.write_addr, bus.write_data);
        end
      end
      tick();
    end
    bus.wb_a_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stream();
    bus.cmd_valid = 1'b1;
    bus.cmd_vl    = 7'd8;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wb_a_valid = (i == 2);
      bus.wb_a_addr  = 6'd6;
      bus.wb_a_data  = 64'hBEEF;
      @(negedge clk);
      checks++;
      if (bus.elem_idx !== 6'(i)) begin
        errors++;
        $display("[TB] FAIL rms_idx i=%0d: got %0d expected %0d", i, bus.elem_idx, i);
      end
      if (i < 3) tick();
    end
    checks++;
    if (bus.write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rms_pending: got write %b expected 1", bus.write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.elem_valid, bus.elem_last, bus.busy, bus.write} !== 5'b10000 || bus.elem_idx !== 6'd0 || bus.rd_addr !== 6'd0 || bus.write_addr !== 6'd0) begin
      errors++;
      $display("[TB] FAIL rms_async: got flags %b idx %0d rd_addr %0d waddr %0d expected 10000 0 0 0", {bus.cmd_ready, bus.elem_valid, bus.elem_last, bus.busy, bus.write}, bus.elem_idx, bus.rd_addr, bus.write_addr);
    end
    tick();
    reset = 1'b0;
    checks++;
    if (mem[6] !== 64'h106) begin
      errors++;
      $display("[TB] FAIL rms_dropped: got mem[6] %h expected 106", mem[6]);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_vl    = 7'd2;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.elem_valid !== 1'b1 || bus.elem_idx !== 6'(i) || bus.elem_data !== 64'h100 + 64'(i) || bus.elem_last !== (i == 1)) begin
        errors++;
        $display("[TB] FAIL rms_restream i=%0d: got v%b idx %0d data %h last %b expected v1 idx %0d data %h last %b", i, bus.elem_valid, bus.elem_idx, bus.elem_data, bus.elem_last, i, 64'h100 + 64'(i), i == 1);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.elem_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rms_done: got cmd_ready %b valid %b expected 1 0", bus.cmd_ready, bus.elem_valid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_vl     = '0;
    bus.elem_ready = 1'b0;
    bus.wb_a_valid = 1'b0;
    bus.wb_a_addr  = '0;
    bus.wb_a_data  = '0;
    bus.wb_b_valid = 1'b0;
    bus.wb_b_addr  = '0;
    bus.wb_b_data  = '0;
    test_reset();
    test_round_robin();
    preload_register();
    test_stream4();
    test_stall();
    test_zero_len();
    test_clamp();
    test_write_during_stream();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_reg_sequencer.md
# vector_reg_sequencer

Controller for one 64 x 64-bit dual-port vector register. The read port streams VL consecutive elements, starting at element 0, to a functional unit over a valid/ready handshake. The single write port is arbitrated between two writeback requesters: A is the ALU result path and B is the memory load path. It sits between the vector issue logic and one vector register instance, drives that register's read_addr/write/write_addr/write_data, and consumes its combinational reg_data.

## Interface
- VECTOR_REG_DEPTH, 64, elements per register; AW = $clog2(VECTOR_REG_DEPTH)
- VECTOR_REG_WIDTH, 64, element width in bits
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  read-stream command valid
- cmd_ready  out  1  sequencer idle and able to accept a command
- cmd_vl  in  AW+1  vector length, elements to stream
- rd_addr  out  AW  to register read_addr
- rd_data  in  VECTOR_REG_WIDTH  from register reg_data (combinational)
- elem_valid  out  1  element stream valid
- elem_ready  in  1  functional unit accepts element
- elem_data  out  VECTOR_REG_WIDTH  element value (= rd_data)
- elem_idx  out  AW  element index
- elem_last  out  1  final element of the command
- busy  out  1  stream in progress
- wb_a_valid / wb_b_valid  in  1  writeback request
- wb_a_ready / wb_b_ready  out  1  grant (handshake completes this cycle)
- wb_a_addr / wb_b_addr  in  AW  target element
- wb_a_data / wb_b_data  in  VECTOR_REG_WIDTH  write value
- write  out  1  to register write
- write_addr  out  AW  to register write_addr
- write_data  out  VECTOR_REG_WIDTH  to register write_data

## Operation
- Read FSM states: IDLE, STREAM.
- IDLE:
  - cmd_ready=1, elem_valid=0, busy=0.
  - On cmd_valid: latch len = min(cmd_vl, VECTOR_REG_DEPTH).
  - If len==0: the command is consumed and the FSM stays in IDLE; no elements are produced.
  - Otherwise: idx=0 and the FSM goes to STREAM.
- STREAM:
  - cmd_ready=0, busy=1, elem_valid=1.
  - rd_addr=idx, elem_idx=idx, elem_data=rd_data, elem_last=(idx==len-1).
  - On elem_valid&&elem_ready: if elem_last, go to IDLE; else idx+1.
  - With elem_ready=0, all element outputs hold.
- In IDLE, rd_addr holds its last value; it is 0 after reset.
- cmd_vl above VECTOR_REG_DEPTH is clamped; idx never wraps.
- Write arbiter, default round-robin:
  - The pointer starts at A after reset.
  - When both requesters are valid, the pointed requester wins and the pointer moves to the other.
  - When only one requester is valid, it wins and the pointer moves to the loser side.
  - At most one of wb_a_ready/wb_b_ready is high; ready is combinational from valid and the pointer.
- Granted addr/data are registered: write=1, write_addr, write_data are driven the cycle after the handshake. write=0 in cycles with no grant.
- The read stream and writeback are independent and may be active in the same cycle. A write to an element being streamed becomes visible on rd_data two cycles after its handshake; no forwarding is performed.

## Timing
- Reset values:
  - cmd_ready=1, elem_valid=0, elem_last=0, elem_idx=0, rd_addr=0, busy=0.
  - write=0, write_addr=0, write_data=0, wb_*_ready=0.
  - State IDLE, pointer=A.
- Reset asserted mid-stream aborts the stream immediately (asynchronously). Any write that is registered but not yet committed is dropped.
- Command acceptance to first elem_valid: 1 cycle.
- Throughput: 1 element/cycle with elem_ready held high. A VL=N stream occupies N STREAM cycles, and cmd_ready returns the cycle after the last handshake.
- Writeback: handshake in cycle t → write=1 in t+1 → data stored at the end of t+1. Sustains 1 write/cycle.

## Configuration
- VREG_SEQ_FIXED_PRIO_EN defined:
  - Fixed priority, A always beats B.
  - The pointer is removed; B is granted only when A is not valid.
- Not defined: round-robin as described in Operation.

## Test plan
- cmd_vl=4, elem_ready=1, register preloaded e[i]=i+0x100:
  - Elements 0x100..0x103 on four consecutive cycles.
  - elem_last only on idx 3.
  - cmd_ready high on the following cycle.
- cmd_vl=3 with elem_ready toggling 1,0,1,0,1: elem_idx/elem_data hold on stall cycles; exactly 3 handshakes occur.
- cmd_vl=0 → no elem_valid and cmd_ready stays 1. cmd_vl=100 → exactly 64 elements, idx 0..63, no wrap.
- A and B both valid for 4 cycles (round-robin):
  - Grants A,B,A,B.
  - write_addr sequence matches, one cycle delayed.
  - With VREG_SEQ_FIXED_PRIO_EN: A,A,A,A.
- During a VL=8 stream at idx 2, A writes element 5=0xDEAD → elem_data at idx 5 = 0xDEAD.
- Reset asserted at idx 3 of a VL=8 stream → outputs immediately at reset values; a new cmd_vl=2 after reset streams idx 0,1.
